// File: rtl/sw_pkg.sv
// Shared definitions for the FASTA base streamer: base encodings, parser
// states, ASCII constants and the byte-to-base conversion helper.
package sw_pkg;

  localparam int STRING_LENGTH = 50;

  typedef logic [1:0] base_t;
  localparam base_t BASE_A = 2'b00;
  localparam base_t BASE_G = 2'b01;
  localparam base_t BASE_T = 2'b10;
  localparam base_t BASE_C = 2'b11;

  typedef enum logic [2:0] {
    Q_HDR  = 3'd0,
    Q_SEQ  = 3'd1,
    DB_HDR = 3'd2,
    DB_SEQ = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_GT = 8'h3E;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef struct packed {
    logic  valid;
    base_t code;
  } enc_t;

  // Case-insensitive nucleotide lookup; anything else comes back with valid=0.
  function automatic enc_t convert_to_base(input logic [7:0] ch);
    enc_t r;
    r.valid = 1'b1;
    r.code  = BASE_A;
    case (ch)
      8'h41, 8'h61: r.code = BASE_A;
      8'h47, 8'h67: r.code = BASE_G;
      8'h54, 8'h74: r.code = BASE_T;
      8'h43, 8'h63: r.code = BASE_C;
      default:      r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fasta_char_decode.sv
// Combinational classifier for one FASTA byte: nucleotide code, whitespace,
// record-header marker and line feed.
module fasta_char_decode
  import sw_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       is_base,
  output logic [1:0] code,
  output logic       is_ws,
  output logic       is_hdr,
  output logic       is_lf
);

  enc_t enc;

  always_comb begin
    enc     = convert_to_base(i_byte);
    is_base = enc.valid;
    code    = enc.code;
    is_lf   = (i_byte == ASCII_LF);
    is_ws   = is_lf || (i_byte == ASCII_CR) || (i_byte == ASCII_SP);
    is_hdr  = (i_byte == ASCII_GT);
  end

endmodule

// File: rtl/fasta_base_streamer.sv
// Parses a FASTA byte stream: the first record is packed into the query
// register, every following record is streamed one 2-bit base per cycle.
module fasta_base_streamer
  import sw_pkg::*;
#(
  parameter int STRING_LENGTH = sw_pkg::STRING_LENGTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_vld,
  input  logic [7:0]                 i_byte,
  input  logic                       i_last,
  output logic                       o_rdy,
  output logic [2*STRING_LENGTH-1:0] o_query,
  output logic [6:0]                 o_query_length,
  output logic                       o_query_vld,
  output logic                       o_vld,
  output logic [1:0]                 o_data,
  output logic                       o_seq_start,
  output logic                       o_seq_end,
  output logic [15:0]                o_seq_idx,
  output logic                       o_err,
  output logic [2:0]                 o_dbg_state
);

  // Handshake: a byte transfers on a rising edge where i_vld && o_rdy;
  // o_rdy is a function of the current state only and never of i_vld.

  localparam logic [6:0] SL_MAX = 7'(STRING_LENGTH);

  logic       dec_is_base;
  logic [1:0] dec_code;
  logic       dec_is_ws;
  logic       dec_is_hdr;
  logic       dec_is_lf;

  fasta_char_decode u_decode (
    .i_byte  (i_byte),
    .is_base (dec_is_base),
    .code    (dec_code),
    .is_ws   (dec_is_ws),
    .is_hdr  (dec_is_hdr),
    .is_lf   (dec_is_lf)
  );

  state_t                     state_q, state_d;
  logic [6:0]                 q_cnt_q, q_cnt_d;
  logic [2*STRING_LENGTH-1:0] query_q, query_d;
  logic [6:0]                 qlen_q, qlen_d;
  logic                       qvld_q, qvld_d;
  logic                       err_q, err_d;
  logic                       vld_q, vld_d;
  logic [1:0]                 data_q, data_d;
  logic                       start_q, start_d;
  logic                       end_q, end_d;
  logic [15:0]                idx_q, idx_d;
  logic                       had_base_q, had_base_d;
  logic                       first_q, first_d;
  logic                       end_pend_q, end_pend_d;
  logic                       accept;

  assign o_rdy  = (state_q == Q_HDR) || (state_q == Q_SEQ) ||
                  (state_q == DB_HDR) || (state_q == DB_SEQ);
  assign accept = i_vld && o_rdy;

  always_comb begin
    state_d    = state_q;
    q_cnt_d    = q_cnt_q;
    query_d    = query_q;
    qlen_d     = qlen_q;
    qvld_d     = qvld_q;
    err_d      = err_q;
    vld_d      = 1'b0;
    data_d     = data_q;
    start_d    = 1'b0;
    end_d      = 1'b0;
    idx_d      = idx_q;
    had_base_d = had_base_q;
    first_d    = first_q;
    end_pend_d = 1'b0;

    if (state_q == GAP) begin
      state_d    = DB_HDR;
      had_base_d = 1'b0;
      if (idx_q != 16'hFFFF) idx_d = idx_q + 16'd1;
    end else if (state_q == DONE) begin
      // A record closed by i_last reports its end one cycle after its last base.
      end_d = end_pend_q;
    end else if (accept) begin
      case (state_q)
        Q_HDR: begin
          if (first_q && !dec_is_ws) begin
            first_d = 1'b0;
            if (!dec_is_hdr) err_d = 1'b1;
          end
          if (dec_is_lf) state_d = Q_SEQ;
        end
        Q_SEQ: begin
          if (dec_is_base) begin
            if (q_cnt_q < SL_MAX) begin
              for (int k = 0; k < STRING_LENGTH; k++) begin
                if (7'(k) == q_cnt_q) query_d[2*k +: 2] = dec_code;
              end
              q_cnt_d = q_cnt_q + 7'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (dec_is_hdr) begin
            qvld_d  = 1'b1;
            state_d = DB_HDR;
            if (q_cnt_q == 7'd0) begin
              err_d  = 1'b1;
              qlen_d = 7'd0;
            end else begin
              qlen_d = q_cnt_q - 7'd1;
            end
          end else if (!dec_is_ws) begin
            err_d = 1'b1;
          end
        end
        DB_HDR: begin
          if (dec_is_lf) state_d = DB_SEQ;
        end
        DB_SEQ: begin
          if (dec_is_base) begin
            vld_d      = 1'b1;
            data_d     = dec_code;
            start_d    = !had_base_q;
            had_base_d = 1'b1;
          end else if (dec_is_hdr) begin
            state_d = GAP;
            end_d   = had_base_q;
          end else if (!dec_is_ws) begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase

      if (i_last) begin
        state_d = DONE;
        end_d   = 1'b0;
        if (state_q == DB_SEQ) begin
          end_pend_d = had_base_q || dec_is_base;
        end else if (!qvld_q) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= Q_HDR;
      q_cnt_q    <= '0;
      query_q    <= '0;
      qlen_q     <= '0;
      qvld_q     <= 1'b0;
      err_q      <= 1'b0;
      vld_q      <= 1'b0;
      data_q     <= '0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      idx_q      <= '0;
      had_base_q <= 1'b0;
      first_q    <= 1'b1;
      end_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_cnt_q    <= q_cnt_d;
      query_q    <= query_d;
      qlen_q     <= qlen_d;
      qvld_q     <= qvld_d;
      err_q      <= err_d;
      vld_q      <= vld_d;
      data_q     <= data_d;
      start_q    <= start_d;
      end_q      <= end_d;
      idx_q      <= idx_d;
      had_base_q <= had_base_d;
      first_q    <= first_d;
      end_pend_q <= end_pend_d;
    end
  end

  assign o_query        = query_q;
  assign o_query_length = qlen_q;
  assign o_query_vld    = qvld_q;
  assign o_err          = err_q;
  assign o_vld          = vld_q;
  assign o_data         = data_q;
  assign o_seq_start    = start_q;
  assign o_seq_end      = end_q;
  assign o_seq_idx      = idx_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_fasta_base_streamer.sv
// Bench for fasta_base_streamer: table of single-byte vectors inside a record,
// hand-written multi-record sequences, and a scoreboard of streamed bases.
module tb_fasta_base_streamer;

  localparam int SL = 50;
  localparam int W  = 51;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_vld = 1'b0;
  logic [7:0]    i_byte = 8'h00;
  logic          i_last = 1'b0;
  logic          o_rdy;
  logic [2*SL-1:0] o_query;
  logic [6:0]    o_query_length;
  logic          o_query_vld;
  logic          o_vld;
  logic [1:0]    o_data;
  logic          o_seq_start;
  logic          o_seq_end;
  logic [15:0]   o_seq_idx;
  logic          o_err;
  logic [2:0]    o_dbg_state;

  fasta_base_streamer #(.STRING_LENGTH(SL)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_vld          (i_vld),
    .i_byte         (i_byte),
    .i_last         (i_last),
    .o_rdy          (o_rdy),
    .o_query        (o_query),
    .o_query_length (o_query_length),
    .o_query_vld    (o_query_vld),
    .o_vld          (o_vld),
    .o_data         (o_data),
    .o_seq_start    (o_seq_start),
    .o_seq_end      (o_seq_end),
    .o_seq_idx      (o_seq_idx),
    .o_err          (o_err),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int end_cnt = 0;
  int end_cyc = 0;
  int last_vld_cyc = 0;
  int rdy_low_cnt = 0;
  bit rand_gaps = 1'b0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_vld  = 1'b0;
    i_last = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
  endtask

  function automatic logic [2:0] enc(input logic [7:0] c);
    case (c)
      8'h41, 8'h61: enc = 3'b100;
      8'h47, 8'h67: enc = 3'b101;
      8'h54, 8'h74: enc = 3'b110;
      8'h43, 8'h63: enc = 3'b111;
      default:      enc = 3'b000;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input logic last, input bit push,
                           input bit start, input int idx, input logic [1:0] code);
    int n;
    n = 0;
    if (rand_gaps) begin
      repeat ($urandom_range(0, 3)) begin
        i_byte = 8'($urandom_range(0, 255));
        i_last = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    i_vld  = 1'b1;
    i_byte = b;
    i_last = last;
    while (!o_rdy && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!o_rdy) begin
      n_checks++;
      n_errors++;
      $display("FAIL rdy_timeout: o_rdy=%0b required 1", o_rdy);
    end else if (push) begin
      exp_q.push_back({32'(cyc + 1), start, 16'(idx), code});
    end
    @(negedge clk);
    i_vld  = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input bit db, input int idx, input bit last_final);
    bit first;
    bit p;
    logic [2:0] e;
    first = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      e = enc(q[i]);
      p = db && e[2];
      send_byte(q[i], last_final && (i == q.size() - 1), p, first && p, idx, e[1:0]);
      if (p) first = 1'b0;
    end
  endtask

  task automatic send_str(input string s, input bit db, input int idx, input bit last_final);
    logic [7:0] q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_bytes(q, db, idx, last_final);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] w;
    if (o_vld === 1'b1) begin
      last_vld_cyc = cyc;
      if (o_seq_start === 1'b1) start_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_vld: got o_vld=1 data=%0b, expected no base", o_data);
      end else begin
        w = exp_q.pop_front();
        chk("sb_beat{cyc,start,idx,data}", {cyc, o_seq_start, o_seq_idx, o_data}, w);
      end
    end else if (o_seq_start === 1'b1) begin
      start_cnt++;
      n_checks++;
      n_errors++;
      $display("FAIL sb_start_without_vld: got o_seq_start=1 o_vld=0, expected no start");
    end
    if (o_seq_end === 1'b1) begin
      end_cnt++;
      end_cyc = cyc;
    end
    if (o_rdy === 1'b0) rdy_low_cnt++;
  end

  // ---------------- sequences ----------------
  task automatic run_basic(input string tag);
    int e0;
    int s0;
    e0 = end_cnt;
    s0 = start_cnt;
    send_str(">q\nACGT\n", 0, 0, 0);
    send_str(">d0\n", 0, 0, 0);
    send_str("GGA", 1, 0, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_query"}, o_query[7:0], 8'h9C);
    chk({tag, "_qlen"}, o_query_length, 7'd3);
    chk({tag, "_qvld"}, o_query_vld, 1'b1);
    chk({tag, "_starts"}, start_cnt - s0, 1);
    chk({tag, "_ends"}, end_cnt - e0, 1);
    chk({tag, "_end_timing"}, end_cyc, last_vld_cyc + 1);
    chk({tag, "_done_rdy"}, o_rdy, 1'b0);
    chk({tag, "_state"}, o_dbg_state, 3'd5);
    chk({tag, "_err"}, o_err, 1'b0);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic run_query(input int n);
    logic [7:0] bases[4];
    logic [7:0] q[$];
    logic [7:0] b;
    logic [2*SL-1:0] exp_query;
    int kept;
    bases = '{8'h41, 8'h43, 8'h47, 8'h54};
    exp_query = '0;
    do_reset();
    send_str(">q\n", 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      b = bases[$urandom_range(0, 3)];
      if (i < SL) exp_query[2*i +: 2] = enc(b)[1:0];
      q.push_back(b);
    end
    send_bytes(q, 0, 0, 0);
    send_str(">", 0, 0, 0);
    kept = (n > SL) ? SL : n;
    chk($sformatf("q%0d_len", n), o_query_length, (n == 0) ? 0 : kept - 1);
    chk($sformatf("q%0d_err", n), o_err, (n == 0 || n > SL) ? 1 : 0);
    chk($sformatf("q%0d_vld", n), o_query_vld, 1'b1);
    chk($sformatf("q%0d_bits", n), o_query, exp_query);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       vld;
    logic [1:0] code;
    logic       err;
  } vec_t;

  initial begin
    vec_t tbl[12];
    bit first;
    int e0;
    int s0;
    logic [7:0] q[$];

    tbl[0]  = '{8'h41, 1'b1, 2'b00, 1'b0};
    tbl[1]  = '{8'h67, 1'b1, 2'b01, 1'b0};
    tbl[2]  = '{8'h74, 1'b1, 2'b10, 1'b0};
    tbl[3]  = '{8'h63, 1'b1, 2'b11, 1'b0};
    tbl[4]  = '{8'h20, 1'b0, 2'b00, 1'b0};
    tbl[5]  = '{8'h0D, 1'b0, 2'b00, 1'b0};
    tbl[6]  = '{8'h0A, 1'b0, 2'b00, 1'b0};
    tbl[7]  = '{8'h47, 1'b1, 2'b01, 1'b0};
    tbl[8]  = '{8'h4E, 1'b0, 2'b00, 1'b1};
    tbl[9]  = '{8'h54, 1'b1, 2'b10, 1'b1};
    tbl[10] = '{8'h61, 1'b1, 2'b00, 1'b1};
    tbl[11] = '{8'h43, 1'b1, 2'b11, 1'b1};

    // reset state
    repeat (2) @(negedge clk);
    do_reset();
    chk("rst_outs", {o_vld, o_data, o_seq_start, o_seq_end, o_seq_idx,
                     o_query_vld, o_query_length, o_err}, 0);
    chk("rst_query", o_query, 0);
    chk("rst_rdy", o_rdy, 1'b1);
    chk("rst_state", o_dbg_state, 3'd0);

    // single query, single record ended by i_last
    run_basic("basic");

    // two records separated by a GAP cycle
    do_reset();
    s0 = start_cnt;
    e0 = end_cnt;
    send_str(">q\nA\n>r0\n", 0, 0, 0);
    send_str("AC", 1, 0, 0);
    rdy_low_cnt = 0;
    send_str(">r1\n", 0, 0, 0);
    chk("two_gap_rdy_low", rdy_low_cnt, 1);
    chk("two_idx_after_gap", o_seq_idx, 16'd1);
    send_str("T", 1, 1, 1);
    repeat (3) @(negedge clk);
    chk("two_starts", start_cnt - s0, 2);
    chk("two_ends", end_cnt - e0, 2);
    chk("two_sb_empty", exp_q.size(), 0);

    // query length boundaries
    run_query(52);
    run_query(50);
    run_query(0);

    // per-byte vectors inside one database record
    do_reset();
    send_str(">q\nA\n>d\n", 0, 0, 0);
    first = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_byte(tbl[i].b, 1'b0, tbl[i].vld, first && tbl[i].vld, 0, tbl[i].code);
      if (tbl[i].vld) first = 1'b0;
      chk($sformatf("tbl%0d_vld", i), o_vld, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), o_data, tbl[i].code);
      chk($sformatf("tbl%0d_err", i), o_err, tbl[i].err);
    end

    // i_last outside a database record with no query yet
    do_reset();
    send_str(">q\nA", 0, 0, 1);
    @(negedge clk);
    chk("early_last_err", o_err, 1'b1);
    chk("early_last_rdy", o_rdy, 1'b0);
    chk("early_last_qvld", o_query_vld, 1'b0);

    // reset in the middle of a database record
    do_reset();
    send_str(">q\nA\n>d\n", 0, 0, 0);
    send_str("GG", 1, 0, 0);
    e0 = end_cnt;
    do_reset();
    chk("midrst_outs", {o_vld, o_data, o_seq_start, o_seq_end, o_seq_idx,
                        o_query_vld, o_query_length, o_err}, 0);
    chk("midrst_query", o_query, 0);
    chk("midrst_rdy", o_rdy, 1'b1);
    repeat (3) @(negedge clk);
    chk("midrst_no_end", end_cnt - e0, 0);
    run_basic("after_rst");

    // random valid gaps while streaming two records
    do_reset();
    rand_gaps = 1'b1;
    s0 = start_cnt;
    e0 = end_cnt;
    send_str(">q\nAC\n>d\n", 0, 0, 0);
    q.delete();
    for (int i = 0; i < 30; i++) q.push_back(8'(enc(8'h41) == 3'b100 ? "ACGTacgt" : "A") );
    q.delete();
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: q.push_back(8'h41);
        1: q.push_back(8'h63);
        2: q.push_back(8'h67);
        default: q.push_back(8'h54);
      endcase
    end
    send_bytes(q, 1, 0, 0);
    send_str(">e\n", 0, 0, 0);
    send_str("TTGCA", 1, 1, 1);
    rand_gaps = 1'b0;
    repeat (4) @(negedge clk);
    chk("rand_sb_empty", exp_q.size(), 0);
    chk("rand_starts", start_cnt - s0, 2);
    chk("rand_ends", end_cnt - e0, 2);
    chk("rand_err", o_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fasta_base_streamer.md
FASTA_BASE_STREAMER -- requirements
Module: fasta_base_streamer

Interface
REQ-001 Parameter STRING_LENGTH, default 50, maximum query length in bases.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset.
REQ-004 i_vld  in  1  byte-source valid.
REQ-005 i_byte  in  8  ASCII FASTA byte.
REQ-006 i_last  in  1  qualifies the final byte of the file; meaningful only with i_vld.
REQ-007 o_rdy  out  1  byte accepted when i_vld and o_rdy are both high.
REQ-008 o_query  out  2*STRING_LENGTH  packed query, bits [0:2*STRING_LENGTH-1]; base k occupies [2k +: 2].
REQ-009 o_query_length  out  7  query base count minus one.
REQ-010 o_query_vld  out  1  level; query and length are stable and valid.
REQ-011 o_vld  out  1  database base valid, aligner i_vld.
REQ-012 o_data  out  2  encoded database base, aligner i_data.
REQ-013 o_seq_start  out  1  one-cycle pulse coincident with the first base of each database record.
REQ-014 o_seq_end  out  1  one-cycle pulse the cycle after the last base of each database record.
REQ-015 o_seq_idx  out  16  index of the current database record, starting at 0.
REQ-016 o_err  out  1  sticky error flag.

Function
REQ-017 Encoding: A/a=00, G/g=01, T/t=10, C/c=11.
REQ-018 Bytes LF (0x0A), CR (0x0D) and space are discarded in every state.
REQ-019 Any other byte in a sequence state is discarded and sets o_err.
REQ-020 FSM states: Q_HDR, Q_SEQ, DB_HDR, DB_SEQ, GAP, DONE. Reset state is Q_HDR.
REQ-021 Q_HDR: all bytes are discarded until an LF is seen, then go to Q_SEQ. The leading '>' is required; a non-'>' first byte sets o_err.
REQ-022 Q_SEQ: each base is written to slot q_cnt, then q_cnt increments.
  - Bases beyond STRING_LENGTH set o_err and are dropped.
  - The query register is cleared at reset only.
REQ-023 Q_SEQ receiving '>':
  - o_query_length = q_cnt-1 and o_query_vld=1 from the next cycle.
  - Go to DB_HDR.
  - If q_cnt=0: set o_err, o_query_length=0.
REQ-024 DB_HDR: bytes are discarded until LF, then go to DB_SEQ.
REQ-025 DB_SEQ base accepted in cycle N:
  - o_vld=1 and o_data=code in cycle N+1; latency exactly 1.
  - o_seq_start accompanies the first base of the record.
REQ-026 DB_SEQ receiving '>':
  - Go to GAP; o_rdy=0 for exactly one cycle.
  - o_seq_end pulses in the GAP cycle if the record had at least one base; no pulse for an empty record.
  - o_seq_idx increments at the end of GAP.
  - Then go to DB_HDR.
REQ-027 o_vld=0 in every cycle without an accepted base. There is always at least one o_vld=0 cycle between database records.
REQ-028 i_last accepted in DB_SEQ:
  - If the byte is a base, it is streamed normally.
  - o_seq_end pulses on the following cycle if the record had a base.
  - Go to DONE.
REQ-029 i_last accepted in any other state: go to DONE and set o_err if o_query_vld=0.
REQ-030 DONE: o_rdy=0; state is held until reset.
REQ-031 o_rdy=1 in Q_HDR, Q_SEQ, DB_HDR and DB_SEQ; 0 in GAP and DONE.
REQ-032 o_seq_idx saturates at 0xFFFF.
REQ-033 No combinational path from inputs to outputs except o_rdy, which depends on state only.

Reset
REQ-034 While rst=0 at a clock edge, all of the following clear to 0: o_vld, o_data, o_seq_start, o_seq_end, o_seq_idx, o_query, o_query_length, o_query_vld, o_err, q_cnt. State returns to Q_HDR.
REQ-035 Reset mid-stream aborts the current record without an o_seq_end pulse; o_rdy=1 the cycle after reset releases.

Structure
REQ-036 Shared package sw_pkg holds:
  - STRING_LENGTH;
  - the base_t 2-bit typedef and its encodings;
  - the ConvertToBase-equivalent encode function, with a valid flag;
  - the FSM state enum;
  - ASCII constants for '>', LF, CR and space.
REQ-037 One sub-module, fasta_char_decode (combinational): byte in; outputs is_base, code, is_ws, is_hdr, is_lf.

Verification
REQ-038 Input ">q\nACGT\n>d0\nGGA\n" with i_last on the final 'A':
  - o_query[0:7]=00_11_01_10, o_query_length=3, o_query_vld=1.
  - Three o_vld cycles carrying data 01,01,00; o_seq_start with the first.
  - o_seq_end the following cycle; then DONE with o_rdy=0.
REQ-039 Two database records "AC" and "T":
  - o_seq_idx is 0 then 1.
  - Exactly one o_vld=0 GAP cycle with o_rdy=0 between them.
  - One o_seq_start and one o_seq_end pulse per record.
REQ-040 Query of 52 bases: o_err=1, o_query_length=49, and the first 50 bases are retained.
REQ-041 Byte 'N' inside a database record: no o_vld for it, o_err=1, and the surrounding bases are unaffected.
REQ-042 rst=0 asserted for one cycle mid-DB_SEQ: all outputs are 0 on the next cycle and no o_seq_end is produced. A fresh file then parses correctly.
REQ-043 i_vld toggled randomly during streaming: the output base sequence is unchanged and each o_vld occurs exactly one cycle after its accepted byte.
